modred_seq: RTL and testbench
=============================

MODRED_SEQ -- requirements
Module: modred_seq

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the modulus width W; the dividend width is 2*W and the quotient width is 2*W.
REQ-002 The module SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The module SHALL have port start  input  1  request to begin one reduction; sampled on rising edges of clk.
REQ-005 The module SHALL have port a  input  2*W  unsigned dividend.
REQ-006 The module SHALL have port modulant  input  W  unsigned modulus.
REQ-007 The module SHALL have port busy  output  1  high while a reduction is in progress.
REQ-008 The module SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-009 The module SHALL have port remainder  output  W  a mod modulant.
REQ-010 The module SHALL have port quotient  output  2*W  floor(a / modulant).
REQ-011 The module SHALL have port div_zero  output  1  high when the accepted modulant was 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 Start SHALL be accepted only in IDLE or DONE. On acceptance, a and modulant SHALL be captured into internal registers, and the input ports SHALL be ignored afterwards.
REQ-014 Start SHALL be ignored while in CALC: no restart, no change to the captured operands.
REQ-015 On acceptance with modulant != 0, the FSM SHALL enter CALC with bit counter = 2*W, and busy SHALL be 1 from the next cycle.
REQ-016 CALC SHALL be a restoring division with one dividend bit per cycle, processed MSB first, using a W+1-bit partial remainder:
  - shift the partial remainder left and bring in the next dividend bit;
  - if the partial remainder >= modulant, subtract modulant and set the quotient bit to 1; otherwise set it to 0.
REQ-017 After exactly 2*W CALC edges, the FSM SHALL enter DONE. done SHALL therefore be visible 2*W cycles after the acceptance edge.
REQ-018 In DONE: done=1 and busy=0 for exactly one cycle, after which the FSM SHALL return to IDLE unless start is accepted on that edge.
REQ-019 A start accepted in DONE SHALL begin the new operation with no idle cycle, giving back-to-back throughput of one result per 2*W+1 cycles.
REQ-020 remainder, quotient and div_zero SHALL be registered. They SHALL be updated only on entry to DONE and held stable until the next entry to DONE.
REQ-021 On acceptance with modulant == 0, the FSM SHALL go directly to DONE without entering CALC, with:
  - div_zero=1;
  - quotient = all ones;
  - remainder = a[W-1:0];
  - done visible 1 cycle after acceptance.
REQ-022 Any non-zero-modulant result SHALL clear div_zero.
REQ-023 The remainder SHALL always be < modulant for modulant != 0, with no final correction step.
REQ-024 Arithmetic SHALL be unsigned throughout, with no overflow at a = 2^(2W)-1 or modulant = 2^W-1.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force:
  - state = IDLE;
  - busy=0, done=0, div_zero=0;
  - remainder=0, quotient=0;
  - bit counter and partial remainder cleared.
REQ-026 Reset asserted during CALC SHALL abort the operation, with no done pulse and no result update.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (W=8)
REQ-028 a=1000, modulant=7, start pulse -> after 16 cycles: done=1 for one cycle, quotient=142, remainder=6, div_zero=0.
REQ-029 a=65535, modulant=255 -> quotient=257, remainder=0. a=65535, modulant=1 -> quotient=65535, remainder=0.
REQ-030 a=5, modulant=9 -> quotient=0, remainder=5. a=0, modulant=200 -> quotient=0, remainder=0.
REQ-031 a=1234, modulant=0 -> one cycle later: done=1, div_zero=1, quotient=65535, remainder=210 (0xD2).
REQ-032 Start with a=1000, modulant=7, then start again with a=9, modulant=4 at CALC cycle 5 -> the second start is ignored; result 142/6 appears at cycle 16.
REQ-033 Reset pulse at CALC cycle 8 -> busy=0 immediately, no done pulse, outputs 0. Then an immediate back-to-back start from DONE (200 mod 3, then 17 mod 5) -> results 66/2, then 3/2, with done pulses 17 cycles apart.

Source files
------------

// File: rtl/modred_seq.sv
// Sequential modular reduction: restoring division of a 2W-bit dividend by a W-bit
// modulus, one dividend bit per clock. Produces quotient, remainder and a divide-by-zero flag.
module modred_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [2*DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]     modulant,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     remainder,
    output logic [2*DATA_WIDTH-1:0]   quotient,
    output logic                      div_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int AW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(AW + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   work;
    logic [W-1:0]    mod_q;
    logic [W-1:0]    pr;
    logic [CW-1:0]   cnt;

    logic [W:0]      pr_shift;
    logic            ge;
    logic [W-1:0]    pr_next;
    logic [AW-1:0]   work_next;

    // The dividend register doubles as the quotient accumulator: its MSB feeds the
    // partial remainder while the new quotient bit enters at the LSB.
    always_comb begin
        pr_shift  = {pr, work[AW-1]};
        ge        = (pr_shift >= {1'b0, mod_q});
        pr_next   = ge ? W'(pr_shift - {1'b0, mod_q}) : pr_shift[W-1:0];
        work_next = {work[AW-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            remainder <= '0;
            quotient  <= '0;
            work      <= '0;
            mod_q     <= '0;
            pr        <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        work  <= a;
                        mod_q <= modulant;
                        pr    <= '0;
                        if (modulant == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            div_zero  <= 1'b1;
                            quotient  <= '1;
                            remainder <= a[W-1:0];
                            cnt       <= '0;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                            cnt   <= CW'(AW);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    work <= work_next;
                    pr   <= pr_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= work_next;
                        remainder <= pr_next;
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modred_seq.sv
// Directed bench for modred_seq (W=8): table of hand-computed reductions plus
// sequences for ignored restart, asynchronous abort and back-to-back operation.
module tb_modred_seq;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [2*W-1:0]   a;
    logic [W-1:0]     modulant;
    logic             busy;
    logic             done;
    logic [W-1:0]     remainder;
    logic [2*W-1:0]   quotient;
    logic             div_zero;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2*W-1:0] a;
        logic [W-1:0]   m;
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           dz;
        int             lat;
    } vec_t;

    modred_seq #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .modulant  (modulant),
        .busy      (busy),
        .done      (done),
        .remainder (remainder),
        .quotient  (quotient),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (!done && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        a        = v.a;
        modulant = v.m;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        a        = ~v.a;
        modulant = ~v.m;
        if (!v.dz) check($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
        wait_done(40, n);
        check($sformatf("v%0d latency", idx), 32'(n), 32'(v.lat));
        check($sformatf("v%0d quotient", idx), 32'(quotient), 32'(v.q));
        check($sformatf("v%0d remainder", idx), 32'(remainder), 32'(v.r));
        check($sformatf("v%0d div_zero", idx), 32'(div_zero), 32'(v.dz));
        tick();
        check($sformatf("v%0d done_drop", idx), 32'(done), 32'd0);
        check($sformatf("v%0d idle_busy", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t vecs[9];
        int   n;
        int   dcount;

        vecs[0] = '{a: 16'd1000,  m: 8'd7,   q: 16'd142,   r: 8'd6,   dz: 1'b0, lat: 16};
        vecs[1] = '{a: 16'd65535, m: 8'd255, q: 16'd257,   r: 8'd0,   dz: 1'b0, lat: 16};
        vecs[2] = '{a: 16'd65535, m: 8'd1,   q: 16'd65535, r: 8'd0,   dz: 1'b0, lat: 16};
        vecs[3] = '{a: 16'd5,     m: 8'd9,   q: 16'd0,     r: 8'd5,   dz: 1'b0, lat: 16};
        vecs[4] = '{a: 16'd0,     m: 8'd200, q: 16'd0,     r: 8'd0,   dz: 1'b0, lat: 16};
        vecs[5] = '{a: 16'd1234,  m: 8'd0,   q: 16'd65535, r: 8'd210, dz: 1'b1, lat: 0};
        vecs[6] = '{a: 16'd100,   m: 8'd3,   q: 16'd33,    r: 8'd1,   dz: 1'b0, lat: 16};
        vecs[7] = '{a: 16'd65535, m: 8'd254, q: 16'd258,   r: 8'd3,   dz: 1'b0, lat: 16};
        vecs[8] = '{a: 16'd65280, m: 8'd255, q: 16'd256,   r: 8'd0,   dz: 1'b0, lat: 16};

        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        modulant = '0;
        #2;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst div_zero", 32'(div_zero), 32'd0);
        check("rst quotient", 32'(quotient), 32'd0);
        check("rst remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Restart attempt at CALC cycle 5 must be ignored
        a        = 16'd1000;
        modulant = 8'd7;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        a        = 16'd9;
        modulant = 8'd4;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(40, n);
        check("restart latency", 32'(5 + n), 32'd16);
        check("restart quotient", 32'(quotient), 32'd142);
        check("restart remainder", 32'(remainder), 32'd6);
        tick();

        // Asynchronous abort at CALC cycle 8
        a        = 16'd200;
        modulant = 8'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort quotient", 32'(quotient), 32'd0);
        check("abort remainder", 32'(remainder), 32'd0);
        tick();
        tick();
        rst_n  = 1'b1;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dcount++;
        end
        check("abort no_done", 32'(dcount), 32'd0);
        check("abort idle_busy", 32'(busy), 32'd0);

        // Back-to-back: second start accepted on the DONE edge
        a        = 16'd200;
        modulant = 8'd3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        a        = 16'd17;
        modulant = 8'd5;
        wait_done(40, n);
        check("b2b1 latency", 32'(n), 32'd16);
        check("b2b1 quotient", 32'(quotient), 32'd66);
        check("b2b1 remainder", 32'(remainder), 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b2 busy", 32'(busy), 32'd1);
        check("b2b2 held_q", 32'(quotient), 32'd66);
        check("b2b2 held_r", 32'(remainder), 32'd2);
        wait_done(40, n);
        check("b2b2 spacing", 32'(n + 1), 32'd17);
        check("b2b2 quotient", 32'(quotient), 32'd3);
        check("b2b2 remainder", 32'(remainder), 32'd2);
        check("b2b2 div_zero", 32'(div_zero), 32'd0);
        tick();
        check("b2b2 done_drop", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
